immediate_encoder: RTL and testbench
====================================

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 The block SHALL expose CLK, input, 1 bit: single system clock; all sequential state updates on its rising edge.
REQ-002 The block SHALL expose RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose INSTRUCTION, input, 32 bits: raw RV32 instruction word.
REQ-004 The block SHALL expose IMM_SEL, input, 3 bits: immediate format select.
REQ-005 The block SHALL expose IMMEDIATE, output, 32 bits: combinational decoded immediate.
REQ-006 The block SHALL expose IMMEDIATE_REG, output, 32 bits: IMMEDIATE registered on CLK.
REQ-007 The block SHALL expose SEL_ERR, output, 1 bit: combinational flag, high when IMM_SEL is a reserved code.

Function
REQ-008 IMMEDIATE SHALL be purely combinational from INSTRUCTION and IMM_SEL, with zero-cycle latency and settling within one simulation time step.
REQ-009 IMM_SEL=000 (I-type) SHALL yield sign-extended inst[31:20].
REQ-010 IMM_SEL=001 (S-type) SHALL yield sign-extended {inst[31:25], inst[11:7]}.
REQ-011 IMM_SEL=010 (B-type) SHALL yield sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
REQ-012 IMM_SEL=011 (U-type) SHALL yield {inst[31:12], 12'b0}.
REQ-013 IMM_SEL=100 (J-type) SHALL yield sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
REQ-014 IMM_SEL=101 (shift amount) SHALL yield zero-extended inst[24:20].
REQ-015 IMM_SEL=110 and 111 SHALL be reserved; IMMEDIATE SHALL be 0 and SEL_ERR SHALL be 1 for these codes.
REQ-016 SEL_ERR SHALL be 0 for every IMM_SEL code from 000 through 101.
REQ-017 Sign extension SHALL always replicate inst[31] into every bit above the format's top bit.
REQ-018 On every rising CLK edge while RESET is low, IMMEDIATE_REG SHALL take the current IMMEDIATE value (one-cycle latency).
REQ-019 The block SHALL have no handshake; the input is sampled every cycle.
REQ-020 An X/Z value on IMM_SEL SHALL be treated as a reserved code (IMMEDIATE=0, SEL_ERR=1).

Reset
REQ-021 RESET high SHALL immediately and asynchronously force IMMEDIATE_REG to 32'h0, independent of CLK.
REQ-022 While RESET is high, IMMEDIATE_REG SHALL stay at 0.
REQ-023 The combinational outputs IMMEDIATE and SEL_ERR SHALL be unaffected by RESET.
REQ-024 On the first rising CLK edge after RESET deasserts, IMMEDIATE_REG SHALL capture IMMEDIATE.

Structure
REQ-025 The IMM_SEL encodings (I, S, B, U, J, SHAMT) SHALL be defined as named constants in the shared CPU package used by the control unit.
REQ-026 The format-decode logic SHALL be one combinational sub-module, imm_format_mux, feeding a single output register in the top module.

Verification
REQ-027 The bench SHALL check I-type: INSTRUCTION=0x74F10093, IMM_SEL=000 -> IMMEDIATE=0x0000074F (1871).
REQ-028 The bench SHALL check S-type: INSTRUCTION={0000001,00001,00010,010,11100,0000011}, IMM_SEL=001 -> IMMEDIATE=0x0000003C (60).
REQ-029 The bench SHALL check B-type: INSTRUCTION={0100101,00001,00010,000,10000,1100011}, IMM_SEL=010 -> IMMEDIATE=0x000004B0 (1200).
REQ-030 The bench SHALL check U-type and J-type:
- U: INSTRUCTION=0x0ABCD0B7, IMM_SEL=011 -> IMMEDIATE=0x0ABCD000.
- J: INSTRUCTION=0x79A150EF, IMM_SEL=100 -> IMMEDIATE=0x0001579A.
REQ-031 The bench SHALL check negative sign extension and the reserved code:
- INSTRUCTION=0xFFF00093, IMM_SEL=000 -> IMMEDIATE=0xFFFFFFFF.
- IMM_SEL=111 -> IMMEDIATE=0 and SEL_ERR=1.
REQ-032 The bench SHALL check register timing and asynchronous reset:
- IMMEDIATE_REG shall equal the prior-cycle IMMEDIATE after one CLK edge.
- Asserting RESET mid-cycle shall force IMMEDIATE_REG to 0 before the next CLK edge.

Source files
------------

// File: rtl/immediate_encoder_pkg.sv
// Shared CPU definitions: immediate-format select codes used by the control
// unit and the immediate encoder.
package immediate_encoder_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101
    } imm_sel_e;

endpackage

// File: rtl/imm_format_mux.sv
// Combinational RV32 immediate decode: selects and sign/zero-extends the
// immediate field of an instruction word according to the format select.
module imm_format_mux
    import immediate_encoder_pkg::*;
(
    input  logic [31:7]     inst,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            sel_err
);

    always_comb begin
        imm     = '0;
        sel_err = 1'b0;
        // Reserved codes and any X/Z on the select fall through to default.
        case (imm_sel)
            IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     imm = {inst[31:12], 12'b0};
            IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, inst[24:20]};
            default: begin
                imm     = '0;
                sel_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immediate_encoder.sv
// Immediate encoder: combinational immediate decode plus a registered copy
// of the decoded immediate for the next pipeline stage.
module immediate_encoder
    import immediate_encoder_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    input  logic [2:0]      IMM_SEL,
    output logic [XLEN-1:0] IMMEDIATE,
    output logic [XLEN-1:0] IMMEDIATE_REG,
    output logic            SEL_ERR
);

    logic [XLEN-1:0] imm_comb;
    logic [XLEN-1:0] immediate_reg_d;
    logic [XLEN-1:0] immediate_reg_q;
    logic            unused_opcode;

    // The opcode field never contributes to any immediate.
    assign unused_opcode = ^INSTRUCTION[6:0];

    imm_format_mux u_imm_format_mux (
        .inst    (INSTRUCTION[31:7]),
        .imm_sel (IMM_SEL),
        .imm     (imm_comb),
        .sel_err (SEL_ERR)
    );

    always_comb begin
        immediate_reg_d = imm_comb;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            immediate_reg_q <= '0;
        end else begin
            immediate_reg_q <= immediate_reg_d;
        end
    end

    assign IMMEDIATE     = imm_comb;
    assign IMMEDIATE_REG = immediate_reg_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: literal vectors plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_immediate_encoder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION = '0;
    logic [2:0]  IMM_SEL = '0;
    logic [31:0] IMMEDIATE;
    logic [31:0] IMMEDIATE_REG;
    logic        SEL_ERR;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    logic [31:0] exp_reg = '0;

    immediate_encoder dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .INSTRUCTION   (INSTRUCTION),
        .IMM_SEL       (IMM_SEL),
        .IMMEDIATE     (IMMEDIATE),
        .IMMEDIATE_REG (IMMEDIATE_REG),
        .SEL_ERR       (SEL_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic longint field(input logic [31:0] w, input int lo, input int width);
        return (longint'(w) >> lo) % (longint'(1) << width);
    endfunction

    // Interpret an n-bit two's-complement value and wrap it into 32 bits.
    function automatic logic [31:0] sext(input longint v, input int nbits);
        longint s;
        s = (v >= (longint'(1) << (nbits - 1))) ? v - (longint'(1) << nbits) : v;
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] w, input logic [2:0] sel);
        case (sel)
            3'd0: return sext(field(w, 20, 12), 12);
            3'd1: return sext(field(w, 25, 7) * 32 + field(w, 7, 5), 12);
            3'd2: return sext(field(w, 31, 1) * 4096 + field(w, 7, 1) * 2048
                              + field(w, 25, 6) * 32 + field(w, 8, 4) * 2, 13);
            3'd3: return 32'(field(w, 12, 20) * 4096);
            3'd4: return sext(field(w, 31, 1) * (longint'(1) << 20) + field(w, 12, 8) * 4096
                              + field(w, 20, 1) * 2048 + field(w, 21, 10) * 2, 21);
            3'd5: return 32'(field(w, 20, 5));
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_err(input logic [2:0] sel);
        return sel > 3'd5;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) exp_reg <= 32'h0;
        else       exp_reg <= model_imm(INSTRUCTION, IMM_SEL);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check32("imm_cycle", IMMEDIATE, model_imm(INSTRUCTION, IMM_SEL));
            check32("err_cycle", {31'b0, SEL_ERR}, {31'b0, model_err(IMM_SEL)});
            check32("reg_cycle", IMMEDIATE_REG, exp_reg);
        end
    end

    task automatic apply_lit(input string name, input logic [31:0] w, input logic [2:0] sel,
                             input logic [31:0] exp, input logic exp_err);
        @(posedge CLK);
        #2;
        INSTRUCTION = w;
        IMM_SEL     = sel;
        #1;
        check32({name, "_imm"}, IMMEDIATE, exp);
        check32({name, "_err"}, {31'b0, SEL_ERR}, {31'b0, exp_err});
        @(posedge CLK);
        #1;
        check32({name, "_reg"}, IMMEDIATE_REG, exp);
    endtask

    initial begin
        logic [31:0] s_inst;
        logic [31:0] b_inst;
        s_inst = {7'b0000001, 5'b00001, 5'b00010, 3'b010, 5'b11100, 7'b0000011};
        b_inst = {7'b0100101, 5'b00001, 5'b00010, 3'b000, 5'b10000, 7'b1100011};

        INSTRUCTION = 32'h74F10093;
        IMM_SEL     = 3'd0;
        #1;
        check32("reset_reg", IMMEDIATE_REG, 32'h0);
        check32("reset_comb", IMMEDIATE, 32'h0000074F);
        repeat (2) @(posedge CLK);
        #1;
        check32("reset_hold", IMMEDIATE_REG, 32'h0);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check32("first_capture", IMMEDIATE_REG, 32'h0000074F);
        chk_en = 1'b1;

        apply_lit("i_type",  32'h74F10093, 3'd0, 32'h0000074F, 1'b0);
        apply_lit("s_type",  s_inst,       3'd1, 32'h0000003C, 1'b0);
        apply_lit("b_type",  b_inst,       3'd2, 32'h000004B0, 1'b0);
        apply_lit("u_type",  32'h0ABCD0B7, 3'd3, 32'h0ABCD000, 1'b0);
        apply_lit("j_type",  32'h79A150EF, 3'd4, 32'h0001579A, 1'b0);
        apply_lit("i_neg",   32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
        apply_lit("shamt",   32'hFFF00093, 3'd5, 32'h0000001F, 1'b0);
        apply_lit("j_neg",   32'h800000EF, 3'd4, 32'hFFF00000, 1'b0);
        apply_lit("rsv_110", 32'hFFFFFFFF, 3'd6, 32'h00000000, 1'b1);
        apply_lit("rsv_111", 32'h74F10093, 3'd7, 32'h00000000, 1'b1);

        // Mid-cycle asynchronous reset must clear the register before any edge.
        apply_lit("pre_rst", 32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        check32("async_rst_reg", IMMEDIATE_REG, 32'h0);
        check32("async_rst_comb", IMMEDIATE, 32'hFFFFFFFF);
        @(posedge CLK);
        #3;
        RESET = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            @(posedge CLK);
            #2;
            INSTRUCTION = $urandom;
            IMM_SEL     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                #1;
                RESET = 1'b1;
                #1;
                check32("rand_async_rst", IMMEDIATE_REG, 32'h0);
                RESET = 1'b0;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
